// File: rtl/w_reg_param.sv
// rtl/w_reg_param.sv - Y86-64 memory/write-back pipeline register with bubble, valid, stall watchdog (optional perf counters: WREG_PERF_CNT_EN)
module w_reg_param #(
    parameter int                 DATA_W      = 64,
    parameter int                 STAT_W      = 4,
    parameter int                 ICODE_W     = 4,
    parameter int                 REG_W       = 4,
    parameter logic [STAT_W-1:0]  BUB_STAT    = 4'h1,
    parameter logic [ICODE_W-1:0] BUB_ICODE   = 4'h1,
    parameter logic [REG_W-1:0]   RNONE       = 4'hF,
    parameter int                 STALL_LIMIT = 16,
    parameter int                 CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               W_stall,
    input  logic               W_bubble,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [ICODE_W-1:0] m_icode,
    input  logic [DATA_W-1:0]  m_valE,
    input  logic [DATA_W-1:0]  m_valM,
    input  logic [REG_W-1:0]   m_dstE,
    input  logic [REG_W-1:0]   m_dstM,
    output logic [STAT_W-1:0]  W_stat,
    output logic [ICODE_W-1:0] W_icode,
    output logic [DATA_W-1:0]  W_valE,
    output logic [DATA_W-1:0]  W_valM,
    output logic [REG_W-1:0]   W_dstE,
    output logic [REG_W-1:0]   W_dstM,
    output logic               W_valid,
    output logic               W_stall_tmo,
    output logic               W_ctl_err,
    output logic [CNT_W-1:0]   W_stall_cnt,
    output logic [CNT_W-1:0]   W_bubble_cnt
);

    // Run counter only needs to reach STALL_LIMIT, where it saturates.
    localparam int RUN_W = $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STALL_LIMIT);
    localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(STALL_LIMIT - 1);

    logic [STAT_W-1:0]  stat_q,  stat_d;
    logic [ICODE_W-1:0] icode_q, icode_d;
    logic [DATA_W-1:0]  vale_q,  vale_d;
    logic [DATA_W-1:0]  valm_q,  valm_d;
    logic [REG_W-1:0]   dste_q,  dste_d;
    logic [REG_W-1:0]   dstm_q,  dstm_d;
    logic               valid_q, valid_d;
    logic               tmo_q,   tmo_d;
    logic               err_q,   err_d;
    logic [RUN_W-1:0]   run_q,   run_d;

    // Next state: stall holds (and feeds the watchdog), bubble loads a NOP, otherwise load.
    always_comb begin
        stat_d  = stat_q;
        icode_d = icode_q;
        vale_d  = vale_q;
        valm_d  = valm_q;
        dste_d  = dste_q;
        dstm_d  = dstm_q;
        valid_d = valid_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        run_d   = run_q;
        if (W_stall) begin
            if (run_q != RUN_MAX) begin
                run_d = run_q + 1'b1;
            end
            // Flag on the same edge the run count reaches the limit.
            if (run_q >= RUN_TRIP) begin
                tmo_d = 1'b1;
            end
            if (W_bubble) begin
                err_d = 1'b1;
            end
        end else begin
            run_d = '0;
            if (W_bubble) begin
                stat_d  = BUB_STAT;
                icode_d = BUB_ICODE;
                vale_d  = '0;
                valm_d  = '0;
                dste_d  = RNONE;
                dstm_d  = RNONE;
                valid_d = 1'b0;
            end else begin
                stat_d  = m_stat;
                icode_d = m_icode;
                vale_d  = m_valE;
                valm_d  = m_valM;
                dste_d  = m_dstE;
                dstm_d  = m_dstM;
                valid_d = 1'b1;
            end
        end
    end

    // Pipeline and flag registers; reset loads the bubble image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q  <= BUB_STAT;
            icode_q <= BUB_ICODE;
            vale_q  <= '0;
            valm_q  <= '0;
            dste_q  <= RNONE;
            dstm_q  <= RNONE;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= '0;
        end else begin
            stat_q  <= stat_d;
            icode_q <= icode_d;
            vale_q  <= vale_d;
            valm_q  <= valm_d;
            dste_q  <= dste_d;
            dstm_q  <= dstm_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            run_q   <= run_d;
        end
    end

    assign W_stat      = stat_q;
    assign W_icode     = icode_q;
    assign W_valE      = vale_q;
    assign W_valM      = valm_q;
    assign W_dstE      = dste_q;
    assign W_dstM      = dstm_q;
    assign W_valid     = valid_q;
    assign W_stall_tmo = tmo_q;
    assign W_ctl_err   = err_q;

`ifdef WREG_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Stall edges count even when bubble is also high; bubbles count only when accepted.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (W_stall) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end else if (W_bubble) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign W_stall_cnt  = stall_cnt_q;
    assign W_bubble_cnt = bubble_cnt_q;
`else
    assign W_stall_cnt  = '0;
    assign W_bubble_cnt = '0;
`endif

endmodule
